// File: rtl/uart_pkg.sv
// Shared types and helpers for the single-clock UART core.
// State encoding, minimum frame length and parity helper.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int MIN_LEN = 5;
    localparam int MAX_W   = 9;

    function automatic logic parity_calc(
        input logic [MAX_W-1:0] data,
        input logic [3:0]       len,
        input logic             odd
    );
        logic p;
        p = odd;
        for (int i = 0; i < MAX_W; i++) begin
            if (4'(i) < len) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, power-of-two depth.
// Callers gate wr_en_i/rd_en_i; the FIFO does no overflow checks.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q;
    logic [AW:0]      rp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wr_en_i) wp_q <= wp_q + (AW+1)'(1);
            if (rd_en_i) rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wp_q[AW-1:0]] <= wr_data_i;
    end

    assign level_o   = wp_q - rp_q;
    assign full_o    = level_o[AW];
    assign empty_o   = (level_o == '0);
    assign rd_data_o = mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/uart_fifo_core.sv
// Single-clock UART: oversampling tick, TX/RX FIFOs, framed TX/RX
// engines with parity, stop-bit checking, overrun and loopback.
`timescale 1ns/1ps
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int OVS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [3:0]                    cfg_len,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
    input  logic                          cfg_loop,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_ovr,
    input  logic                          ovr_clr,
    output logic                          txd,
    input  logic                          rxd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

    localparam int TCW = $clog2(2*OVS);
    localparam logic [TCW-1:0] T_HALF = TCW'(OVS/2 - 1);
    localparam logic [TCW-1:0] T_BIT  = TCW'(OVS - 1);
    localparam logic [TCW-1:0] T_BIT2 = TCW'(2*OVS - 1);
    localparam logic [3:0]     LEN_MIN = 4'(MIN_LEN);
    localparam logic [3:0]     LEN_MAX = 4'(DATA_W);

    uart_state_e tx_st_q;
    uart_state_e rx_st_q;

    // divisor only reloads while both engines idle, so it holds per frame
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] bcnt_q;
    logic             tick;

    assign tick = (bcnt_q >= div_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_q <= '0;
            div_q  <= '0;
        end else begin
            bcnt_q <= tick ? '0 : bcnt_q + DIV_W'(1);
            if (tx_st_q == IDLE && rx_st_q == IDLE) div_q <= baud_div;
        end
    end

    logic [3:0] len_eff;

    always_comb begin
        len_eff = cfg_len;
        if (cfg_len < LEN_MIN) len_eff = LEN_MIN;
        else if (cfg_len > LEN_MAX) len_eff = LEN_MAX;
    end

    logic              tx_full;
    logic              tx_empty;
    logic              tx_pop;
    logic              tx_push;
    logic [DATA_W-1:0] tx_rdata;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (tx_push),
        .wr_data_i (tx_data),
        .rd_en_i   (tx_pop),
        .rd_data_o (tx_rdata),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .level_o   (tx_level)
    );

    logic [TCW-1:0]    tx_tc_q;
    logic [3:0]        tx_bit_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic              tx_par_q;
    logic [3:0]        tx_len_q;
    logic              tx_pen_q;
    logic              tx_s2_q;
    logic              txd_q;
    logic              tx_end;

    assign tx_end = tick &&
        (tx_tc_q == ((tx_st_q == STOP && tx_s2_q) ? T_BIT2 : T_BIT));
    assign tx_pop = tick && !tx_empty &&
        (tx_st_q == IDLE || (tx_st_q == STOP && tx_end));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q  <= IDLE;
            tx_tc_q  <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_len_q <= LEN_MAX;
            tx_pen_q <= 1'b0;
            tx_s2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else if (tx_pop) begin
            tx_st_q  <= START;
            tx_tc_q  <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= tx_rdata;
            tx_par_q <= parity_calc(MAX_W'(tx_rdata), len_eff, cfg_par_odd);
            tx_len_q <= len_eff;
            tx_pen_q <= cfg_par_en;
            tx_s2_q  <= cfg_stop2;
            txd_q    <= 1'b0;
        end else if (tick && tx_st_q != IDLE) begin
            if (!tx_end) begin
                tx_tc_q <= tx_tc_q + TCW'(1);
            end else begin
                tx_tc_q <= '0;
                unique case (tx_st_q)
                    START: begin
                        tx_st_q <= DATA;
                        txd_q   <= tx_sh_q[0];
                    end
                    DATA: begin
                        if (tx_bit_q == tx_len_q - 4'd1) begin
                            tx_st_q <= tx_pen_q ? PARITY : STOP;
                            txd_q   <= tx_pen_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                            tx_sh_q  <= tx_sh_q >> 1;
                            txd_q    <= tx_sh_q[1];
                        end
                    end
                    PARITY: begin
                        tx_st_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                    default: begin
                        tx_st_q <= IDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_busy = (tx_st_q != IDLE);
    assign txd     = cfg_loop ? 1'b1 : txd_q;

    logic rx_in;
    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rx_line;
    logic rx_fall;

    assign rx_in   = cfg_loop ? txd_q : rxd;
    assign rx_line = s2_q;
    assign rx_fall = s3_q && !s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    logic [TCW-1:0]      rx_tc_q;
    logic [3:0]          rx_bit_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_perr_q;
    logic                rx_ferr_q;
    logic                rx_stop_q;
    logic [3:0]          rx_len_q;
    logic                rx_pen_q;
    logic                rx_odd_q;
    logic                rx_s2_q;
    logic                rx_push_q;
    logic [DATA_W+1:0]   rx_word_q;
    logic                rx_smp;

    assign rx_smp = tick &&
        (rx_tc_q == ((rx_st_q == START) ? T_HALF : T_BIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st_q   <= IDLE;
            rx_tc_q   <= '0;
            rx_bit_q  <= '0;
            rx_data_q <= '0;
            rx_perr_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_stop_q <= 1'b0;
            rx_len_q  <= LEN_MAX;
            rx_pen_q  <= 1'b0;
            rx_odd_q  <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_push_q <= 1'b0;
            rx_word_q <= '0;
        end else begin
            rx_push_q <= 1'b0;
            if (rx_st_q == IDLE) begin
                // a falling edge needs the line high first, so a
                // stuck-low line after a framing error cannot re-arm
                if (rx_fall) begin
                    rx_st_q   <= START;
                    rx_tc_q   <= '0;
                    rx_bit_q  <= '0;
                    rx_data_q <= '0;
                    rx_perr_q <= 1'b0;
                    rx_ferr_q <= 1'b0;
                    rx_stop_q <= 1'b0;
                    rx_len_q  <= len_eff;
                    rx_pen_q  <= cfg_par_en;
                    rx_odd_q  <= cfg_par_odd;
                    rx_s2_q   <= cfg_stop2;
                end
            end else if (tick) begin
                if (!rx_smp) begin
                    rx_tc_q <= rx_tc_q + TCW'(1);
                end else begin
                    rx_tc_q <= '0;
                    unique case (rx_st_q)
                        START: rx_st_q <= rx_line ? IDLE : DATA;
                        DATA: begin
                            rx_data_q <= rx_data_q |
                                (DATA_W'(rx_line) << rx_bit_q);
                            if (rx_bit_q == rx_len_q - 4'd1)
                                rx_st_q <= rx_pen_q ? PARITY : STOP;
                            else
                                rx_bit_q <= rx_bit_q + 4'd1;
                        end
                        PARITY: begin
                            rx_perr_q <= rx_line ^ parity_calc(
                                MAX_W'(rx_data_q), rx_len_q, rx_odd_q);
                            rx_st_q <= STOP;
                        end
                        STOP: begin
                            if (rx_s2_q && !rx_stop_q) begin
                                rx_stop_q <= 1'b1;
                                rx_ferr_q <= rx_ferr_q | !rx_line;
                            end else begin
                                rx_push_q <= 1'b1;
                                rx_word_q <= {rx_ferr_q | !rx_line,
                                              rx_perr_q, rx_data_q};
                                rx_st_q   <= IDLE;
                            end
                        end
                        default: rx_st_q <= IDLE;
                    endcase
                end
            end
        end
    end

    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              rx_wr;
    logic              rx_drop;
    logic [DATA_W+1:0] rx_rdata;
    logic              ovr_q;

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_wr    = rx_push_q && (!rx_full || rx_pop);
    assign rx_drop  = rx_push_q && rx_full && !rx_pop;

    uart_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (rx_wr),
        .wr_data_i (rx_word_q),
        .rd_en_i   (rx_pop),
        .rd_data_o (rx_rdata),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .level_o   (rx_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovr_q <= 1'b0;
        else if (rx_drop) ovr_q <= 1'b1;
        else if (ovr_clr) ovr_q <= 1'b0;
    end

    assign rx_ovr  = ovr_q;
    assign rx_data = rx_rdata[DATA_W-1:0];
    assign rx_perr = rx_rdata[DATA_W];
    assign rx_ferr = rx_rdata[DATA_W+1];

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at baud_div=3, OVS=16
// (64 clk per bit), default 8-bit data and 16-deep FIFOs.
`timescale 1ns/1ps
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [3:0]  cfg_len;
    logic        cfg_par_en;
    logic        cfg_par_odd;
    logic        cfg_stop2;
    logic        cfg_loop;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_ovr;
    logic        ovr_clr;
    logic        txd;
    logic        rxd;
    logic        tx_busy;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;

    int total = 0;
    int bad   = 0;

    logic [7:0] rd [3];
    logic       rp [3];
    logic       rf [3];

    uart_fifo_core dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .cfg_len     (cfg_len),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .cfg_loop    (cfg_loop),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_ovr      (rx_ovr),
        .ovr_clr     (ovr_clr),
        .txd         (txd),
        .rxd         (rxd),
        .tx_busy     (tx_busy),
        .tx_level    (tx_level),
        .rx_level    (rx_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tx_frame(input logic [7:0] d);
        logic tr [900];
        int   busy;
        int   st;
        logic [9:0] ex;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        busy = 0;
        st   = -1;
        for (int i = 0; i < 900; i++) begin
            tr[i] = txd;
            if (tx_busy) busy++;
            if (st < 0 && !txd) st = i;
            @(negedge clk);
        end
        ex = {1'b1, d, 1'b0};
        chk("tx_start_seen", 32'(st >= 0), 1);
        if (st >= 0 && st < 200) begin
            for (int k = 0; k < 10; k++)
                chk($sformatf("tx_bit%0d", k), 32'(tr[st+32+64*k]),
                    32'(ex[k]));
            chk("tx_start_end", 32'(tr[st+63]), 0);
            chk("tx_idle_after", 32'(tr[st+700]), 1);
        end
        chk("tx_busy_len", busy, 640);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic pen,
                           input logic pbit, input logic stopv);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = d[k];
            repeat (64) @(negedge clk);
        end
        if (pen) begin
            rxd = pbit;
            repeat (64) @(negedge clk);
        end
        rxd = stopv;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pop1;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int low;
        int n;
        logic ok;
        logic [7:0] first;
        logic [7:0] last;

        rst = 1'b0;
        baud_div = 16'd3;
        cfg_len = 4'd8;
        cfg_par_en = 1'b0;
        cfg_par_odd = 1'b0;
        cfg_stop2 = 1'b0;
        cfg_loop = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        rx_ready = 1'b0;
        ovr_clr = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_ovr", rx_ovr, 0);
        chk("rst_txlvl", tx_level, 0);
        chk("rst_rxlvl", rx_level, 0);
        chk("rst_txrdy", tx_ready, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        tx_frame(8'hA5);

        cfg_loop = 1'b1;
        cfg_len = 4'd7;
        cfg_par_en = 1'b1;
        cfg_stop2 = 1'b1;
        @(negedge clk);
        foreach (rd[i]) begin
            tx_data = (i == 0) ? 8'h3C : (i == 1) ? 8'h41 : 8'h7F;
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        got = 0;
        low = 0;
        for (int i = 0; i < 3000 && got < 3; i++) begin
            if (!txd) low++;
            if (rx_valid) begin
                rd[got] = rx_data;
                rp[got] = rx_perr;
                rf[got] = rx_ferr;
                got++;
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("lb_count", got, 3);
        chk("lb_txd_low", low, 0);
        if (got == 3) begin
            chk("lb_d0", rd[0], 8'h3C);
            chk("lb_d1", rd[1], 8'h41);
            chk("lb_d2", rd[2], 8'h7F);
            chk("lb_err", {rp[0], rf[0], rp[1], rf[1], rp[2], rf[2]}, 0);
        end
        repeat (100) @(negedge clk);
        cfg_loop = 1'b0;
        cfg_len = 4'd8;
        cfg_stop2 = 1'b0;
        cfg_par_odd = 1'b1;
        repeat (10) @(negedge clk);

        // 0x55 has four ones: odd parity bit is 1, send 0 instead
        rx_send(8'h55, 1'b1, 1'b0, 1'b1);
        chk("pe_valid", rx_valid, 1);
        chk("pe_data", rx_data, 8'h55);
        chk("pe_perr", rx_perr, 1);
        chk("pe_ferr", rx_ferr, 0);
        chk("pe_level", rx_level, 1);
        pop1();

        cfg_par_en = 1'b0;
        cfg_par_odd = 1'b0;
        repeat (10) @(negedge clk);
        rx_send(8'hA3, 1'b0, 1'b0, 1'b0);
        chk("fe_valid", rx_valid, 1);
        chk("fe_data", rx_data, 8'hA3);
        chk("fe_ferr", rx_ferr, 1);
        chk("fe_perr", rx_perr, 0);
        pop1();
        repeat (200) @(negedge clk);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (900) @(negedge clk);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_level", rx_level, 0);

        cfg_loop = 1'b1;
        @(negedge clk);
        for (int w = 1; w <= 17; w++) begin
            tx_data = 8'(w);
            tx_valid = 1'b1;
            n = 0;
            ok = 1'b0;
            while (!ok && n < 2000) begin
                ok = tx_ready;
                @(negedge clk);
                n++;
            end
            chk($sformatf("ovr_push%0d", w), ok, 1);
        end
        tx_valid = 1'b0;
        chk("txf_full_lvl", tx_level, 16);
        chk("txf_full_rdy", tx_ready, 0);
        ok = 1'b0;
        for (int i = 0; i < 15000 && !ok; i++) begin
            if (tx_level == 0 && !tx_busy) ok = 1'b1;
            @(negedge clk);
        end
        chk("ovr_drain", ok, 1);
        repeat (10) @(negedge clk);
        chk("ovr_level", rx_level, 16);
        chk("ovr_flag", rx_ovr, 1);
        first = rx_data;
        last = '0;
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            last = rx_data;
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("ovr_first", first, 8'd1);
        chk("ovr_last", last, 8'd16);
        chk("ovr_empty", rx_valid, 0);
        chk("ovr_sticky", rx_ovr, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", rx_ovr, 0);

        cfg_loop = 1'b0;
        @(negedge clk);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_busy", tx_busy, 1);
        repeat (200) @(negedge clk);
        chk("mid_txd", txd, 0);
        chk("mid_lvl", tx_level, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_txd", txd, 1);
        chk("arst_busy", tx_busy, 0);
        chk("arst_txlvl", tx_level, 0);
        chk("arst_rdy", tx_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rxlvl", rx_level, 0);
        tx_frame(8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
